step_sequencer: RTL and testbench
=================================

STEP_SEQUENCER -- requirements
Module: step_sequencer

Interface
REQ-001 Parameters SHALL be (one per line: name, default, meaning):
  STEPS, 8, number of pattern steps (power of two)
  TEMPO_W, 24, width of the tempo and gate-length counters
REQ-002 Ports SHALL be (name  direction  width  meaning):
  clk  in  1  system clock, all logic on posedge
  rst  in  1  synchronous, active-high reset
  en  in  1  advance enable; low freezes all counters and outputs
  start  in  1  pulse: begin playback at step 0
  stop  in  1  pulse: end playback
  wr_en  in  1  pattern write strobe
  wr_addr  in  log2(STEPS)  pattern write address
  wr_data  in  14  step word: [13] rest, [12:11] octave, [10:0] note switches
  tempo  in  TEMPO_W  clk cycles per step
  gate_len  in  TEMPO_W  clk cycles gate is high within a step
  sw_out  out  11  note switch code to frequency divider
  octave_out  out  2  octave code to frequency divider
  gate  out  1  note sounding; drives wavetable enable
  step_idx  out  log2(STEPS)  step currently playing
  busy  out  1  high in PLAY and HOLD
REQ-003 Clock and reset SHALL be one clock, clk, with synchronous active-high reset, rst.

Function
REQ-004 FSM states SHALL be IDLE, PLAY (gate window), HOLD (gate released, step continues).
REQ-005 IDLE + start SHALL, next cycle: state PLAY, step_idx=0, sw_out/octave_out=pattern[0], gate=!rest[0], step counter=0.
REQ-006 In PLAY/HOLD with en high, the step counter SHALL increment each cycle; with en low, all state SHALL hold.
REQ-007 PLAY SHALL go to HOLD (gate=0) the cycle the step counter reaches gate_len; gate_len>=tempo SHALL keep gate high for the whole step (legato); gate_len==0 SHALL never assert gate.
REQ-008 When the step counter reaches tempo-1, the next cycle SHALL load step_idx+1 exactly as REQ-005; tempo==0 SHALL be treated as 1.
REQ-009 A rest step SHALL hold gate low for the entire step, with sw_out/octave_out still updated.
REQ-010 After the last step (STEPS-1), behaviour SHALL follow REQ-018.
REQ-011 start during PLAY/HOLD SHALL restart at step 0 (REQ-005); stop SHALL go to IDLE next cycle with gate=0; stop and start together: stop wins.
REQ-012 Pattern writes SHALL be accepted in every state; a write to the playing step SHALL take effect only on its next load.
REQ-013 sw_out, octave_out and step_idx SHALL hold their last values in IDLE; gate and busy SHALL be 0 in IDLE.
REQ-014 All outputs SHALL be registered; start-to-gate latency SHALL be exactly 1 cycle.

Reset
REQ-015 rst SHALL force IDLE, gate=0, busy=0, step_idx=0, sw_out=0, octave_out=0 and counters=0, overriding all other inputs, including mid-step.
REQ-016 Pattern memory SHALL be cleared to 0 by rst (14'h0000: non-rest, note code 0).

Configuration
REQ-017 Macro SEQ_LOOP_EN SHALL select end-of-pattern behaviour.
REQ-018 With SEQ_LOOP_EN defined, step STEPS-1 SHALL wrap to step 0 and continue; without it, the end of step STEPS-1 SHALL go to IDLE (gate=0, busy=0).

Structure
REQ-019 Shared package synth_seq_pkg SHALL hold the FSM state enum, step-word field positions (REST_BIT, OCT_MSB/LSB, SW_MSB/LSB) and the default STEPS.
REQ-020 One sub-module, step_timer (TEMPO_W counter with clear, enable, gate_len and tempo terminal flags), SHALL be instantiated.

Verification
REQ-021 tempo=4, gate_len=2, pattern[i]={0,2'd1,11'(i+1)}, pulse start -> gate pattern 1,1,0,0 per step; sw_out 1,2,3... changing every 4 cycles.
REQ-022 pattern[2] rest=1 -> gate low all of step 2; sw_out=3 during step 2.
REQ-023 gate_len=0 -> gate never high; gate_len=10 with tempo=4 -> gate continuously high while busy.
REQ-024 en low 3 cycles mid-step -> step_idx/gate frozen; step ends 3 cycles late.
REQ-025 stop and start together in PLAY -> IDLE next cycle; rst mid-step -> all outputs 0 next cycle.
REQ-026 Step STEPS-1 end -> step_idx=0 with SEQ_LOOP_EN, IDLE and busy=0 without.

Source files
------------

// File: rtl/synth_seq_pkg.sv
// Shared types and step-word layout for the pattern step sequencer.
// Holds the FSM state enum, step-word field positions and default depth.
package synth_seq_pkg;

  localparam int STEPS_DEF = 8;
  localparam int WORD_W    = 14;

  localparam int REST_BIT = 13;
  localparam int OCT_MSB  = 12;
  localparam int OCT_LSB  = 11;
  localparam int SW_MSB   = 10;
  localparam int SW_LSB   = 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_HOLD
  } seq_state_t;

  function automatic logic word_rest(
    input logic [WORD_W-1:0] w
  );
    return w[REST_BIT];
  endfunction

endpackage

// File: rtl/step_sequencer_timer.sv
// step_timer: per-step cycle counter with clear/enable and
// terminal flags for the gate window and the step length.
module step_timer #(
  parameter int TEMPO_W = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  input  logic [TEMPO_W-1:0] tempo,
  input  logic [TEMPO_W-1:0] gate_len,
  output logic [TEMPO_W-1:0] cnt,
  output logic               gate_end,
  output logic               step_end
);

  logic [TEMPO_W-1:0] tempo_m1;
  logic [TEMPO_W:0]   cnt_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + TEMPO_W'(1);
    end
  end

  // tempo of zero behaves as a one-cycle step
  always_comb begin
    tempo_m1 = '0;
    if (tempo != '0) begin
      tempo_m1 = tempo - TEMPO_W'(1);
    end
  end

  assign cnt_p1   = {1'b0, cnt} + (TEMPO_W+1)'(1);
  assign gate_end = (cnt_p1 == {1'b0, gate_len});
  assign step_end = (cnt >= tempo_m1);

endmodule

// File: rtl/step_sequencer.sv
// step_sequencer: plays a STEPS-deep pattern of note words with tempo/gate timing.
// Define SEQ_LOOP_EN to wrap after the last step instead of stopping.
module step_sequencer
  import synth_seq_pkg::*;
#(
  parameter int STEPS   = STEPS_DEF,
  parameter int TEMPO_W = 24,
  localparam int AW     = $clog2(STEPS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               start,
  input  logic               stop,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [WORD_W-1:0]  wr_data,
  input  logic [TEMPO_W-1:0] tempo,
  input  logic [TEMPO_W-1:0] gate_len,
  output logic [10:0]        sw_out,
  output logic [1:0]         octave_out,
  output logic               gate,
  output logic [AW-1:0]      step_idx,
  output logic               busy
);

  localparam logic [AW-1:0] LAST = AW'(STEPS-1);

  logic [WORD_W-1:0]  mem [STEPS];
  seq_state_t         state;
  logic               load;
  logic               to_idle;
  logic [AW-1:0]      load_idx;
  logic [WORD_W-1:0]  ld_word;
  logic               ld_gate;
  logic               tmr_clr;
  logic               tmr_en;
  logic [TEMPO_W-1:0] cnt;
  logic               gate_end;
  logic               step_end;

  step_timer #(
    .TEMPO_W (TEMPO_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (tmr_clr),
    .en       (tmr_en),
    .tempo    (tempo),
    .gate_len (gate_len),
    .cnt      (cnt),
    .gate_end (gate_end),
    .step_end (step_end)
  );

  assign tmr_clr = load | to_idle;
  assign tmr_en  = en & (state != S_IDLE);

  // stop beats start; both beat the running step
  always_comb begin
    load     = 1'b0;
    to_idle  = 1'b0;
    load_idx = '0;
    if (en) begin
      if (stop) begin
        to_idle = 1'b1;
      end else if (start) begin
        load = 1'b1;
      end else if (state != S_IDLE && step_end) begin
        if (step_idx == LAST) begin
`ifdef SEQ_LOOP_EN
          load = 1'b1;
`else
          to_idle = 1'b1;
`endif
        end else begin
          load     = 1'b1;
          load_idx = step_idx + AW'(1);
        end
      end
    end
  end

  assign ld_word = mem[load_idx];
  assign ld_gate = ~word_rest(ld_word) & (gate_len != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      gate       <= 1'b0;
      busy       <= 1'b0;
      step_idx   <= '0;
      sw_out     <= '0;
      octave_out <= '0;
      for (int i = 0; i < STEPS; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem[wr_addr] <= wr_data;
      end
      if (to_idle) begin
        state <= S_IDLE;
        gate  <= 1'b0;
        busy  <= 1'b0;
      end else if (load) begin
        state      <= S_PLAY;
        step_idx   <= load_idx;
        sw_out     <= ld_word[SW_MSB:SW_LSB];
        octave_out <= ld_word[OCT_MSB:OCT_LSB];
        gate       <= ld_gate;
        busy       <= 1'b1;
      end else if (en && state == S_PLAY && gate_end) begin
        state <= S_HOLD;
        gate  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_step_sequencer.sv
// Randomized scoreboard bench for step_sequencer against a
// step/position reference model of the pattern player.
module tb_step_sequencer;

  localparam int STEPS = 8;
  localparam int TW    = 24;
  localparam int AW    = 3;
`ifdef SEQ_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          en;
  logic          start;
  logic          stop;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [13:0]   wr_data;
  logic [TW-1:0] tempo;
  logic [TW-1:0] gate_len;
  logic [10:0]   sw_out;
  logic [1:0]    octave_out;
  logic          gate;
  logic [AW-1:0] step_idx;
  logic          busy;

  step_sequencer #(
    .STEPS   (STEPS),
    .TEMPO_W (TW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .start      (start),
    .stop       (stop),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .tempo      (tempo),
    .gate_len   (gate_len),
    .sw_out     (sw_out),
    .octave_out (octave_out),
    .gate       (gate),
    .step_idx   (step_idx),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int sw;
    int oct;
    int gate;
    int idx;
    int busy;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // reference model: playing flag, step number, position in step
  int m_mem[STEPS];
  bit m_play;
  int m_idx;
  int m_pos;
  int m_word;

  function automatic void m_load(int i);
    m_idx  = i;
    m_word = m_mem[i];
    m_pos  = 0;
    m_play = 1'b1;
  endfunction

  task automatic model_step();
    int t;
    int nw;
    t = (tempo == 0) ? 1 : int'(tempo);
    if (rst) begin
      m_play = 1'b0;
      m_idx  = 0;
      m_pos  = 0;
      m_word = 0;
      for (int i = 0; i < STEPS; i++) m_mem[i] = 0;
    end else begin
      nw = m_mem[int'(wr_addr)];
      if (wr_en) nw = int'(wr_data);
      if (en) begin
        if (stop) begin
          m_play = 1'b0;
        end else if (start) begin
          m_load(0);
        end else if (m_play) begin
          if (m_pos == t - 1) begin
            if (m_idx == STEPS - 1 && !LOOP) m_play = 1'b0;
            else m_load((m_idx + 1) % STEPS);
          end else begin
            m_pos++;
          end
        end
      end
      m_mem[int'(wr_addr)] = nw;
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.sw   = m_word % 2048;
    e.oct  = (m_word / 2048) % 4;
    e.busy = int'(m_play);
    e.idx  = m_idx;
    e.gate = (m_play && (m_word / 8192) == 0
              && m_pos < int'(gate_len)) ? 1 : 0;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    exp_q.push_back(model_out());
    @(negedge clk);
    cyc++;
  endtask

  task automatic chk(string nm, int got, int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, cyc, got, exp);
    end
  endtask

  // monitor: outputs are presented every cycle; compare on negedge
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sw_out", int'(sw_out), e.sw);
      chk("octave_out", int'(octave_out), e.oct);
      chk("gate", int'(gate), e.gate);
      chk("step_idx", int'(step_idx), e.idx);
      chk("busy", int'(busy), e.busy);
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic load_ramp();
    wr_en = 1'b1;
    for (int i = 0; i < STEPS; i++) begin
      wr_addr = AW'(i);
      wr_data = {1'b0, 2'd1, 11'(i + 1)};
      tick();
    end
    wr_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; start = 1'b0; stop = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    tempo = TW'(4); gate_len = TW'(2);
    m_play = 1'b0; m_idx = 0; m_pos = 0; m_word = 0;
    for (int i = 0; i < STEPS; i++) m_mem[i] = 0;
    tick(); tick();
    rst = 1'b0;
    tick();
    load_ramp();
    pulse_start();
    repeat (40) tick();
    pulse_stop();
    tick();
    // rest on step 2
    wr_en = 1'b1; wr_addr = AW'(2);
    wr_data = {1'b1, 2'd1, 11'd3};
    tick();
    wr_en = 1'b0;
    pulse_start();
    repeat (20) tick();
    pulse_stop();
    gate_len = '0;
    pulse_start();
    repeat (12) tick();
    pulse_stop();
    gate_len = TW'(10);
    pulse_start();
    repeat (12) tick();
    pulse_stop();
    // freeze mid-step
    gate_len = TW'(2);
    pulse_start();
    tick();
    en = 1'b0;
    repeat (3) tick();
    en = 1'b1;
    repeat (10) tick();
    // write to the playing step mid-step
    wr_en = 1'b1; wr_addr = step_idx;
    wr_data = {1'b0, 2'd3, 11'h7ff};
    tick();
    wr_en = 1'b0;
    repeat (10) tick();
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    tick();
    pulse_start();
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    load_ramp();
    tempo = TW'(1);
    pulse_start();
    repeat (10) tick();
    pulse_stop();
    tempo = '0;
    gate_len = TW'(1);
    pulse_start();
    repeat (10) tick();
    pulse_stop();
    // randomized phase
    for (int n = 0; n < 2500; n++) begin
      if (!m_play && $urandom_range(0, 5) == 0) begin
        tempo    = TW'($urandom_range(0, 5));
        gate_len = TW'($urandom_range(0, 7));
      end
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_addr = AW'($urandom_range(0, STEPS - 1));
      wr_data = 14'($urandom);
      start   = ($urandom_range(0, 29) == 0);
      stop    = ($urandom_range(0, 79) == 0);
      en      = ($urandom_range(0, 9) != 0);
      rst     = ($urandom_range(0, 399) == 0);
      tick();
    end
    rst = 1'b0; start = 1'b0; stop = 1'b0;
    wr_en = 1'b0; en = 1'b1;
    for (int k = 0; k < 5 && exp_q.size() > 0; k++) begin
      @(negedge clk);
    end
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
